vga_timing_gen: RTL and testbench

Raster timing source for the demo display pipeline. Generates the 640x480 @ 60 Hz pixel coordinates, active-video flag and sync pulses consumed by `graphics_engine`. It also synchronises the external mode-switch inputs and re-times them to the frame boundary, so mode changes never tear mid-frame. Runs on the single 25.175 MHz pixel clock.

---
 rtl/vga_timing_pkg.sv | 65 ++++++
 rtl/vga_timing_gen_sync_2ff.sv | 37 +++
 rtl/vga_timing_gen.sv | 120 ++++++++++++
 tb/tb_vga_timing_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//
// Shared constants for the 640x480 @ 60 Hz raster and the mode bus.
// The same package is imported by vga_timing_gen and graphics_engine, so
// the mode-bit indices defined here are the single source of truth for
// what each bit of video_modes means.
//
// Contents:
//   - default horizontal / vertical timing and derived totals
//   - default sync window bounds (first and last counter value asserted)
//   - mode bus width and per-bit index constants
//   - small helpers for window decode and sync polarity
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    // Horizontal timing, in pixel clocks
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    // Vertical timing, in lines
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Sync windows: inclusive first/last counter values where sync is asserted
    localparam int H_SYNC_FIRST_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_LAST_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF - 1;
    localparam int V_SYNC_FIRST_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_LAST_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF - 1;

    // Sync polarity: 0 means the pulse is driven low
    localparam bit SYNC_POL_DEF = 1'b0;

    // Mode bus
    localparam int MODE_W_DEF = 7;

    typedef enum logic [2:0] {
        MODE_NEGATIVE  = 3'd0,
        MODE_MIRROR    = 3'd1,
        MODE_DOUBLE    = 3'd2,
        MODE_PALETTE   = 3'd3,
        MODE_SPRITES   = 3'd4,
        MODE_SCROLL    = 3'd5,
        MODE_ANIMATION = 3'd6
    } mode_bit_e;

    // Inclusive window decode on a 10-bit counter
    function automatic logic in_window(input logic [9:0] ctr,
                                       input logic [9:0] first,
                                       input logic [9:0] last);
        return (ctr >= first) && (ctr <= last);
    endfunction

    // Map "pulse asserted" onto the physical pin level
    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//
// Parameterised-width two-flop synchroniser for quasi-static asynchronous
// inputs (switches). Each bit is synchronised independently; a multi-bit
// change may therefore resolve over two adjacent cycles, which downstream
// logic hides by sampling only at the frame boundary.
//
// Ports:
//   clk    in  1      destination clock
//   rst_n  in  1      asynchronous active-low reset, clears both stages
//   d      in  WIDTH  asynchronous input
//   q      out WIDTH  synchronised output (two clocks of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= '0;
            q       <= '0;
        end else begin
            // stage 0: may go metastable; stage 1: settled copy
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing source for the display pipeline. Produces pixel
// coordinates, active-video flag, sync pulses and a frame-start strobe,
// and re-times the external mode switches so that the mode bus only
// changes at the start of vertical blank.
//
// Ports:
//   clk           in  1       pixel clock (single domain)
//   rst_n         in  1       asynchronous active-low reset
//   mode_pins     in  MODE_W  asynchronous mode switches
//   x             out 10      horizontal position 0..H_TOTAL-1
//   y             out 9       low 9 bits of the line counter
//   frame_active  out 1       visible pixel
//   h_sync        out 1       horizontal sync at SYNC_POL
//   v_sync        out 1       vertical sync at SYNC_POL
//   frame_start   out 1       one-cycle strobe with (x, line) = (0, 0)
//   video_modes   out MODE_W  mode bus, updated only at start of v-blank
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = SYNC_POL_DEF,
    parameter int MODE_W   = MODE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] mode_pins,
    output logic [9:0]        x,
    output logic [8:0]        y,
    output logic              frame_active,
    output logic              h_sync,
    output logic              v_sync,
    output logic              frame_start,
    output logic [MODE_W-1:0] video_modes
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // All counter comparisons are done at 10 bits
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END    = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0]        h_ctr;
    logic [9:0]        v_ctr;
    logic [9:0]        h_nxt;
    logic [9:0]        v_nxt;
    logic              h_wrap;
    logic              v_wrap;
    logic              modes_latch;
    logic [MODE_W-1:0] mode_sync;

    sync_2ff #(
        .WIDTH (MODE_W)
    ) u_mode_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mode_pins),
        .q     (mode_sync)
    );

    // Next-state raster position. Every output flop is loaded from these
    // values, so all outputs describe the same pixel in the same cycle.
    always_comb begin
        h_wrap = (h_ctr == H_LAST);
        v_wrap = (v_ctr == V_LAST);
        h_nxt  = h_wrap ? 10'd0 : h_ctr + 10'd1;
        v_nxt  = v_ctr;
        if (h_wrap) begin
            v_nxt = v_wrap ? 10'd0 : v_ctr + 10'd1;
        end
        // First pixel of the first blank line: the mode bus changes only here
        modes_latch = (h_nxt == 10'd0) && (v_nxt == V_ACT_END);
    end

    // Reset parks the raster on the last blank pixel so that the first edge
    // after release presents (0,0) with frame_start, exactly like a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_ctr        <= H_LAST;
            v_ctr        <= V_LAST;
            x            <= H_LAST;
            y            <= V_LAST[8:0];
            frame_active <= 1'b0;
            frame_start  <= 1'b0;
            h_sync       <= ~SYNC_POL;
            v_sync       <= ~SYNC_POL;
            video_modes  <= '0;
        end else begin
            h_ctr        <= h_nxt;
            v_ctr        <= v_nxt;
            x            <= h_nxt;
            y            <= v_nxt[8:0];
            frame_active <= (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
            frame_start  <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
            h_sync       <= sync_level(in_window(h_nxt, H_SYNC_FIRST, H_SYNC_LAST), SYNC_POL);
            v_sync       <= sync_level(in_window(v_nxt, V_SYNC_FIRST, V_SYNC_LAST), SYNC_POL);
            if (modes_latch) begin
                video_modes <= mode_sync;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share clock, reset and mode pins: u_a uses the full
// 640x480 timing with active-low syncs; u_b uses a shrunken raster
// (80x55 clocks) with active-high syncs so that whole frames fit in a
// short run. Expected outputs come from raster arithmetic on the number of
// clock edges since reset release.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    // Full-size raster
    localparam int A_HA = 640, A_HFP = 16, A_HS = 96, A_HBP = 48;
    localparam int A_VA = 480, A_VFP = 10, A_VS = 2,  A_VBP = 33;
    localparam int A_HT = A_HA + A_HFP + A_HS + A_HBP;
    localparam int A_VT = A_VA + A_VFP + A_VS + A_VBP;
    // Shrunken raster
    localparam int B_HA = 64, B_HFP = 4, B_HS = 8, B_HBP = 4;
    localparam int B_VA = 48, B_VFP = 2, B_VS = 2, B_VBP = 3;
    localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
    localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;
    localparam int B_FR = B_HT * B_VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] mode_pins = 7'h00;

    logic [9:0] xa, xb;
    logic [8:0] ya, yb;
    logic       fa_a, fa_b, hs_a, hs_b, vs_a, vs_b, fs_a, fs_b;
    logic [6:0] vm_a, vm_b;

    int n_vec = 0;
    int n_err = 0;
    int k = 0;              // clock edges since reset release
    logic [6:0] em_a = 7'h00;
    logic [6:0] em_b = 7'h00;

    always #5 clk = ~clk;

    vga_timing_gen u_a (
        .clk(clk), .rst_n(rst_n), .mode_pins(mode_pins),
        .x(xa), .y(ya), .frame_active(fa_a), .h_sync(hs_a), .v_sync(vs_a),
        .frame_start(fs_a), .video_modes(vm_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .SYNC_POL(1'b1), .MODE_W(7)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .mode_pins(mode_pins),
        .x(xb), .y(yb), .frame_active(fa_b), .h_sync(hs_b), .v_sync(vs_b),
        .frame_start(fs_b), .video_modes(vm_b)
    );

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (k=%0d)", name, act, req, k);
        end
    endtask

    // Expected {x, y, frame_active, h_sync, v_sync, frame_start, modes}
    // for edge count kk. kk=0 maps to the last pixel of the frame, which is
    // exactly the reset state.
    function automatic logic [29:0] model(input int kk, input int ha, input int hfp,
                                          input int hs, input int hbp, input int va,
                                          input int vfp, input int vs, input int vbp,
                                          input logic pol, input logic [6:0] modes);
        int ht, vt, fr, pos, px, ln;
        logic fa, h, v, fs;
        ht  = ha + hfp + hs + hbp;
        vt  = va + vfp + vs + vbp;
        fr  = ht * vt;
        pos = (kk + fr - 1) % fr;
        px  = pos % ht;
        ln  = pos / ht;
        fa  = (px < ha) && (ln < va);
        h   = (px >= ha + hfp && px < ha + hfp + hs) ? pol : ~pol;
        v   = (ln >= va + vfp && ln < va + vfp + vs) ? pol : ~pol;
        fs  = (pos == 0);
        return {10'(px), 9'(ln), fa, h, v, fs, modes};
    endfunction

    // Edge counter and mode bus model: the pins present at the edge that
    // enters the first blank line are what the bus must show afterwards.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k    <= 0;
            em_a <= 7'h00;
            em_b <= 7'h00;
        end else begin
            k <= k + 1;
            if (k % (A_HT * A_VT) == A_VA * A_HT) em_a <= mode_pins;
            if (k % B_FR == B_VA * B_HT) em_b <= mode_pins;
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        cmp("raster_a", {xa, ya, fa_a, hs_a, vs_a, fs_a, vm_a},
            model(k, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP, 1'b0, em_a));
        cmp("raster_b", {xb, yb, fa_b, hs_b, vs_b, fs_b, vm_b},
            model(k, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, 1'b1, em_b));
    end

    task automatic wait_k(input int target);
        int guard = 0;
        while (k != target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        cmp("wait_k_reached", 64'(k), 64'(target));
    endtask

    int hs_low, hs_first, hs_last, fa_fall, vs_cnt, fa_cnt, hsb_cnt, fs_k, guard;
    logic fa_prev;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        cmp("rst_a_x", 64'(xa), 64'd799);
        cmp("rst_a_y", 64'(ya), 64'd12);
        cmp("rst_a_fa_fs", {fa_a, fs_a}, 2'b00);
        cmp("rst_a_syncs", {hs_a, vs_a}, 2'b11);
        cmp("rst_b_x_y", {xb, yb}, {10'd79, 9'd54});
        cmp("rst_b_syncs", {hs_b, vs_b}, 2'b00);

        rst_n = 1'b1;
        @(negedge clk);
        cmp("first_a_xy", {xa, ya}, 19'd0);
        cmp("first_a_fa_fs", {fa_a, fs_a}, 2'b11);
        cmp("first_b_fs", 64'(fs_b), 64'd1);

        // One full-size line: h_sync window and active-video edge
        hs_low = 0; hs_first = -1; hs_last = -1; fa_fall = -1; fa_prev = 1'b1;
        for (int i = 0; i < A_HT; i++) begin
            if (i > 0) @(negedge clk);
            if (hs_a == 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(xa);
                hs_last = int'(xa);
            end
            if (fa_prev && !fa_a && fa_fall < 0) fa_fall = int'(xa);
            fa_prev = fa_a;
        end
        cmp("a_hsync_low_clocks", 64'(hs_low), 64'd96);
        cmp("a_hsync_first_x", 64'(hs_first), 64'd656);
        cmp("a_hsync_last_x", 64'(hs_last), 64'd751);
        cmp("a_active_fall_x", 64'(fa_fall), 64'd640);
        @(negedge clk);
        cmp("a_line1_start", {xa, ya}, {10'd0, 9'd1});

        // Mode bus on the small raster: pins change at (10,20)
        wait_k(20 * B_HT + 10 + 1);
        mode_pins = 7'h55;
        wait_k(B_VA * B_HT);
        cmp("b_modes_before_latch", 64'(vm_b), 64'h00);
        wait_k(B_VA * B_HT + 1);
        cmp("b_modes_at_latch", 64'(vm_b), 64'h55);
        cmp("b_latch_pos", {xb, yb, fa_b}, {10'd0, 9'd48, 1'b0});
        wait_k(B_VA * B_HT + 6);
        mode_pins = 7'h2A;

        // One full small frame: sync/active counts and frame period
        wait_k(B_FR + 1);
        vs_cnt = 0; fa_cnt = 0; hsb_cnt = 0; fs_k = -1;
        for (int i = 0; i < B_FR; i++) begin
            if (i > 0) @(negedge clk);
            if (vs_b) vs_cnt++;
            if (fa_b) fa_cnt++;
            if (i < B_HT && hs_b) hsb_cnt++;
            if (fs_b) fs_k = k;
            if (i == B_VA * B_HT - 1) cmp("b_modes_held", 64'(vm_b), 64'h55);
            if (i == B_VA * B_HT) cmp("b_modes_next_frame", 64'(vm_b), 64'h2A);
        end
        cmp("b_vsync_high_clocks", 64'(vs_cnt), 64'd160);
        cmp("b_active_clocks", 64'(fa_cnt), 64'd3072);
        cmp("b_hsync_high_clocks", 64'(hsb_cnt), 64'd8);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!fs_b && guard < 5000);
        cmp("b_frame_period", 64'(k - fs_k), 64'd4400);

        // Asynchronous reset mid-frame at small-raster (30,25)
        wait_k(2 * B_FR + 25 * B_HT + 30 + 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("async_rst_a", {xa, ya, fa_a, hs_a, vs_a, fs_a, vm_a},
            {10'd799, 9'd12, 1'b0, 1'b1, 1'b1, 1'b0, 7'h00});
        cmp("async_rst_b", {xb, yb, fa_b, hs_b, vs_b, fs_b, vm_b},
            {10'd79, 9'd54, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00});
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmp("restart_a", {xa, ya, fa_a, fs_a}, {10'd0, 9'd0, 1'b1, 1'b1});
        cmp("restart_b", {xb, yb, fa_b, fs_b, vm_b}, {10'd0, 9'd0, 1'b1, 1'b1, 7'h00});

        repeat (100) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
